// File: rtl/analog_sensor_scanner_pkg.sv
// Shared types and default constants for the analog mux/ADC sweep scanner.
// Holds the FSM state encoding, the channel type, and the default parameter values.
package analog_sensor_scanner_pkg;

    localparam int CH_W              = 3;
    localparam int DEF_NUM_CH        = 8;
    localparam int DEF_CLK_DIV       = 50;
    localparam int DEF_SETTLE_CYCLES = 4;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        COMPARE
    } state_t;

endpackage

// File: rtl/adc_clk_gen.sv
// ADC conversion clock divider: clk_out toggles every CLK_DIV clocks; rise_tick flags the cycle before each rising edge.
// Latency: first rise_tick CLK_DIV clocks after hold drops; no backpressure, hold parks the divider at zero.
module adc_clk_gen
    import analog_sensor_scanner_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    output logic clk_out,
    output logic rise_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          at_end;

    assign at_end    = (div_cnt == CW'(CLK_DIV - 1));
    assign rise_tick = at_end && !clk_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            clk_out <= 1'b0;
        end else if (hold) begin
            div_cnt <= '0;
            clk_out <= 1'b0;
        end else if (at_end) begin
            div_cnt <= '0;
            clk_out <= ~clk_out;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/analog_sensor_scanner.sv
// Sweeps an external 8:1 mux + ADC, samples each channel after settling, and publishes the per-sweep minimum.
// Latency: one sample per (SETTLE_CYCLES+1)*2*CLK_DIV clocks; no backpressure, enable low abandons the sweep.
module analog_sensor_scanner
    import analog_sensor_scanner_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] analog_input,
    output logic       clk_out,
    output logic [2:0] new_address,
    output logic [2:0] min_address,
    output logic [7:0] min_value,
    output logic       sample_valid,
    output logic [7:0] sample_data,
    output logic [2:0] sample_ch,
    output logic       sweep_done
);

    localparam int  SW      = $clog2(SETTLE_CYCLES + 1);
    localparam ch_t LAST_CH = ch_t'(NUM_CH - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] settle_cnt, settle_nxt;
    ch_t           addr_nxt, run_ch, run_ch_nxt, cand_ch;
    ch_t           min_addr_nxt, sch_nxt;
    logic [7:0]    run_val, run_val_nxt, cand_val;
    logic [7:0]    min_val_nxt, sdata_nxt;
    logic          valid_nxt, done_nxt, take;
    logic          rise_tick;

    adc_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clock     (clock),
        .reset     (reset),
        .hold      (state == IDLE),
        .clk_out   (clk_out),
        .rise_tick (rise_tick)
    );

    always_comb begin
        state_nxt    = state;
        settle_nxt   = settle_cnt;
        addr_nxt     = new_address;
        run_val_nxt  = run_val;
        run_ch_nxt   = run_ch;
        min_addr_nxt = min_address;
        min_val_nxt  = min_value;
        sdata_nxt    = sample_data;
        sch_nxt      = sample_ch;
        valid_nxt    = 1'b0;
        done_nxt     = 1'b0;
        // Channel 0 always seeds the running minimum, so no per-sweep clear is needed.
        take         = (sample_data < run_val) || (sample_ch == '0);
        cand_val     = take ? sample_data : run_val;
        cand_ch      = take ? sample_ch : run_ch;

        if (state != IDLE && !enable) begin
            state_nxt  = IDLE;
            addr_nxt   = '0;
            settle_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_nxt   = SETTLE;
                        addr_nxt    = '0;
                        settle_nxt  = '0;
                        run_val_nxt = 8'hFF;
                        run_ch_nxt  = '0;
                    end
                end
                SETTLE: begin
                    if (rise_tick) begin
                        settle_nxt = settle_cnt + 1'b1;
                        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                            state_nxt = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (rise_tick) begin
                        sdata_nxt = analog_input;
                        sch_nxt   = new_address;
                        valid_nxt = 1'b1;
                        state_nxt = COMPARE;
                    end
                end
                COMPARE: begin
                    run_val_nxt = cand_val;
                    run_ch_nxt  = cand_ch;
                    if (new_address == LAST_CH) begin
                        min_addr_nxt = cand_ch;
                        min_val_nxt  = cand_val;
                        done_nxt     = 1'b1;
                        addr_nxt     = '0;
                    end else begin
                        addr_nxt = new_address + 3'd1;
                    end
                    settle_nxt = '0;
                    state_nxt  = SETTLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            new_address  <= '0;
            run_val      <= 8'hFF;
            run_ch       <= '0;
            min_address  <= '0;
            min_value    <= 8'hFF;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            settle_cnt   <= settle_nxt;
            new_address  <= addr_nxt;
            run_val      <= run_val_nxt;
            run_ch       <= run_ch_nxt;
            min_address  <= min_addr_nxt;
            min_value    <= min_val_nxt;
            sample_data  <= sdata_nxt;
            sample_ch    <= sch_nxt;
            sample_valid <= valid_nxt;
            sweep_done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_analog_sensor_scanner.sv
// Directed bench: a small-parameter scanner for sweep/min behaviour and a default-parameter one for timing.
module tb_analog_sensor_scanner;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int last_sv = 0;

    // Small configuration: NUM_CH=4, CLK_DIV=2, SETTLE_CYCLES=1
    logic       en_s = 1'b0;
    logic [7:0] chan [4];
    logic [7:0] ain_s;
    logic       clk_out_s, sv_s, done_s;
    logic [2:0] addr_s, min_addr_s, sch_s;
    logic [7:0] min_val_s, sd_s;

    assign ain_s = chan[addr_s[1:0]];

    analog_sensor_scanner #(
        .NUM_CH        (4),
        .CLK_DIV       (2),
        .SETTLE_CYCLES (1)
    ) dut_s (
        .clock        (clock),
        .reset        (reset),
        .enable       (en_s),
        .analog_input (ain_s),
        .clk_out      (clk_out_s),
        .new_address  (addr_s),
        .min_address  (min_addr_s),
        .min_value    (min_val_s),
        .sample_valid (sv_s),
        .sample_data  (sd_s),
        .sample_ch    (sch_s),
        .sweep_done   (done_s)
    );

    // Default configuration
    logic       en_d  = 1'b0;
    logic [7:0] ain_d = 8'h00;
    logic       clk_out_d, sv_d, done_d;
    logic [2:0] addr_d, min_addr_d, sch_d;
    logic [7:0] min_val_d, sd_d;

    analog_sensor_scanner dut_d (
        .clock        (clock),
        .reset        (reset),
        .enable       (en_d),
        .analog_input (ain_d),
        .clk_out      (clk_out_d),
        .new_address  (addr_d),
        .min_address  (min_addr_d),
        .min_value    (min_val_d),
        .sample_valid (sv_d),
        .sample_data  (sd_d),
        .sample_ch    (sch_d),
        .sweep_done   (done_d)
    );

    task automatic test_reset();
        int bad;
        en_s  = 1'b0;
        en_d  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if ({clk_out_s, addr_s, min_addr_s, min_val_s, sd_s, sch_s, sv_s, done_s} !==
            {1'b0, 3'd0, 3'd0, 8'hFF, 8'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_small: clk=%b addr=%0d min_addr=%0d min_val=%h data=%h ch=%0d sv=%b done=%b, want 0 0 0 ff 00 0 0 0",
                     clk_out_s, addr_s, min_addr_s, min_val_s, sd_s, sch_s, sv_s, done_s);
        end
        n_tests++;
        if ({clk_out_d, addr_d, min_addr_d, min_val_d, sd_d, sch_d, sv_d, done_d} !==
            {1'b0, 3'd0, 3'd0, 8'hFF, 8'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_default: clk=%b addr=%0d min_addr=%0d min_val=%h data=%h ch=%0d sv=%b done=%b, want 0 0 0 ff 00 0 0 0",
                     clk_out_d, addr_d, min_addr_d, min_val_d, sd_d, sch_d, sv_d, done_d);
        end
        bad = 0;
        repeat (100) begin
            @(posedge clock);
            #1;
            if (clk_out_s !== 1'b0 || clk_out_d !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_clk_static: clk_out high in %0d of 100 cycles, want 0", bad);
        end
    endtask

    // One full sweep of the small DUT, checking each sample, its spacing and the final commit.
    task automatic run_sweep(input string name, input int first_gap,
                             input logic [2:0] exp_addr, input logic [7:0] exp_val,
                             input logic [2:0] old_addr, input logic [7:0] old_val);
        int  gap;
        bit  seen;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clock);
                #1;
                if (sv_s === 1'b1) seen = 1'b1;
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL %s_timeout: no sample_valid for ch%0d within 40 cycles", name, k);
                return;
            end
            gap     = cyc - last_sv;
            last_sv = cyc;
            n_tests++;
            if (gap !== ((k == 0) ? first_gap : 8) || sd_s !== chan[k] || sch_s !== 3'(k) ||
                done_s !== 1'b0 || min_addr_s !== old_addr || min_val_s !== old_val) begin
                n_fail++;
                $display("FAIL %s_sample%0d: gap=%0d data=%h ch=%0d done=%b min=%0d/%h, want gap=%0d data=%h ch=%0d done=0 min=%0d/%h",
                         name, k, gap, sd_s, sch_s, done_s, min_addr_s, min_val_s,
                         (k == 0) ? first_gap : 8, chan[k], k, old_addr, old_val);
            end
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (done_s !== 1'b1 || sv_s !== 1'b0 || min_addr_s !== exp_addr ||
            min_val_s !== exp_val || addr_s !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_commit: done=%b sv=%b min=%0d/%h addr=%0d, want done=1 sv=0 min=%0d/%h addr=0",
                     name, done_s, sv_s, min_addr_s, min_val_s, addr_s, exp_addr, exp_val);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_pulse: sweep_done=%b one cycle later, want 0", name, done_s);
        end
    endtask

    task automatic test_sweep_min();
        chan = '{8'd40, 8'd12, 8'd90, 8'd12};
        en_s = 1'b1;
        last_sv = cyc;
        run_sweep("tie_min", 7, 3'd1, 8'd12, 3'd0, 8'hFF);
    endtask

    task automatic test_all_ff();
        en_s = 1'b0;
        @(posedge clock);
        #1;
        chan = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        en_s = 1'b1;
        last_sv = cyc;
        run_sweep("all_ff", 7, 3'd0, 8'hFF, 3'd1, 8'd12);
        chan[3] = 8'h00;
        run_sweep("ch3_zero", 8, 3'd3, 8'h00, 3'd0, 8'hFF);
    endtask

    task automatic test_enable_drop();
        int got, bad;
        en_s = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chan = '{8'd1, 8'd2, 8'd3, 8'd4};
        en_s = 1'b1;
        got  = 0;
        for (int i = 0; i < 60 && got < 2; i++) begin
            @(posedge clock);
            #1;
            if (sv_s === 1'b1) got++;
        end
        n_tests++;
        if (got !== 2) begin
            n_fail++;
            $display("FAIL drop_prefix: saw %0d sample_valid pulses, want 2", got);
        end
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if (addr_s !== 3'd2) begin
            n_fail++;
            $display("FAIL drop_on_ch2: new_address=%0d, want 2", addr_s);
        end
        en_s = 1'b0;
        @(posedge clock);
        #1;
        n_tests++;
        if (addr_s !== 3'd0 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: new_address=%0d sweep_done=%b, want 0 0", addr_s, done_s);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clock);
            #1;
            if (sv_s !== 1'b0 || done_s !== 1'b0 || clk_out_s !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0 || min_addr_s !== 3'd3 || min_val_s !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_hold: %0d active cycles, min=%0d/%h, want 0 active, min=3/00",
                     bad, min_addr_s, min_val_s);
        end
        chan = '{8'd5, 8'd6, 8'd7, 8'd8};
        en_s = 1'b1;
        last_sv = cyc;
        run_sweep("restart", 7, 3'd0, 8'd5, 3'd3, 8'h00);
    endtask

    task automatic test_async_reset();
        bit seen;
        int bad;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (sv_s === 1'b1 && sch_s === 3'd0) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL areset_wait: no ch0 sample_valid within 60 cycles");
        end
        repeat (4) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        n_tests++;
        if ({clk_out_s, addr_s, min_addr_s, min_val_s, sd_s, sch_s, sv_s, done_s} !==
            {1'b0, 3'd0, 3'd0, 8'hFF, 8'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_values: clk=%b addr=%0d min_addr=%0d min_val=%h data=%h ch=%0d sv=%b done=%b, want 0 0 0 ff 00 0 0 0",
                     clk_out_s, addr_s, min_addr_s, min_val_s, sd_s, sch_s, sv_s, done_s);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (sv_s !== 1'b0 || done_s !== 1'b0) bad++;
        end
        en_s  = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (sv_s !== 1'b0 || done_s !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL areset_no_pulse: %0d cycles with a pulse, want 0", bad);
        end
    endtask

    task automatic test_default_timing();
        int  t0, r1, r2, tsv;
        logic prev;
        r1 = -1;
        r2 = -1;
        tsv = -1;
        prev = clk_out_d;
        ain_d = 8'h33;
        en_d  = 1'b1;
        t0    = cyc;
        for (int i = 0; i < 600 && tsv < 0; i++) begin
            @(posedge clock);
            #1;
            if (clk_out_d === 1'b1 && prev === 1'b0) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev = clk_out_d;
            if (sv_d === 1'b1) tsv = cyc;
        end
        n_tests++;
        if (r1 - t0 !== 51) begin
            n_fail++;
            $display("FAIL dflt_first_rise: first clk_out rise %0d clocks after enable, want 51", r1 - t0);
        end
        n_tests++;
        if (r2 - r1 !== 100) begin
            n_fail++;
            $display("FAIL dflt_period: clk_out period %0d, want 100", r2 - r1);
        end
        n_tests++;
        if (tsv - t0 !== 451 || sd_d !== 8'h33 || sch_d !== 3'd0) begin
            n_fail++;
            $display("FAIL dflt_first_sample: at %0d clocks data=%h ch=%0d, want 451 33 0",
                     tsv - t0, sd_d, sch_d);
        end
        en_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep_min();
        test_all_ff();
        test_enable_drop();
        test_async_reset();
        test_default_timing();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/analog_sensor_scanner.md
# analog_sensor_scanner

Sweeps the external 8:1 analog multiplexer and ADC that feed the goalie controller. It drives the mux select and ADC conversion clock, samples each channel after a settling interval, and publishes the channel with the lowest reading from each complete sweep. Its outputs drive the processor's `new_address`, `clk_out` and `min_address` IO, and it consumes `analog_input` from the board.

## Interface
- `NUM_CH`, 8: channels per sweep; range 2..8; mux select is 3 bits.
- `CLK_DIV`, 50: `clock` cycles per `clk_out` half-period; must be ≥2.
- `SETTLE_CYCLES`, 4: `clk_out` rising edges discarded after each mux switch; must be ≥1.
- `clock`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; high runs continuous sweeps.
- `analog_input`  in  8  ADC parallel output, unsigned.
- `clk_out`  out  1  ADC conversion clock.
- `new_address`  out  3  mux select currently driven.
- `min_address`  out  3  lowest-reading channel of the last completed sweep.
- `min_value`  out  8  reading at `min_address`.
- `sample_valid`  out  1  one-cycle pulse; `sample_data`/`sample_ch` are new.
- `sample_data`  out  8  latest captured reading.
- `sample_ch`  out  3  channel of `sample_data`.
- `sweep_done`  out  1  one-cycle pulse; `min_*` just updated.

## Operation
- Reset values: `clk_out`=0, `new_address`=0, `min_address`=0, `min_value`=8'hFF, `sample_data`=0, `sample_ch`=0, `sample_valid`=0, `sweep_done`=0, state IDLE.
- Divider: `div_cnt` counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and `clk_out` toggles. `rise_tick` is asserted in the cycle where `div_cnt`==CLK_DIV-1 and `clk_out`==0.
- In IDLE, `div_cnt` and `clk_out` are held at 0.
- States:
  - IDLE: on `enable`, go to SETTLE with `new_address`=0, `settle_cnt`=0, and running min reset to {value 8'hFF, ch 0}.
  - SETTLE: each `rise_tick` increments `settle_cnt`. A `rise_tick` with `settle_cnt`==SETTLE_CYCLES-1 goes to SAMPLE.
  - SAMPLE: on `rise_tick`, capture `analog_input` into `sample_data`, set `sample_ch`=`new_address`, pulse `sample_valid`, and go to COMPARE.
  - COMPARE (exactly one cycle): if `sample_data` < running min (strict), or the channel is 0, the running min takes this sample. Ties keep the lower channel.
    - If `new_address`==NUM_CH-1: commit running min to `min_address`/`min_value`, pulse `sweep_done`, set `new_address`=0.
    - Otherwise set `new_address` += 1.
    - Then go to SETTLE with `settle_cnt`=0.
- `enable` low in any non-IDLE state goes to IDLE on the next edge. The partial sweep is discarded; `min_*` hold their last committed values; `new_address` returns to 0.
- `min_*` change only on `sweep_done`.
- Async reset mid-sweep: all outputs go to reset values immediately; no pulse is emitted.

## Timing
- `clk_out` period = 2·CLK_DIV clocks. `rise_tick`s are 2·CLK_DIV clocks apart; the first comes CLK_DIV clocks after leaving IDLE.
- Per channel: SETTLE_CYCLES+1 `rise_tick`s. The mux is stable ≥ SETTLE_CYCLES full `clk_out` periods before capture.
- `analog_input` is sampled on the `clock` edge that ends the `rise_tick` cycle, i.e. the edge on which `clk_out` rises.
- `sample_valid` is high in the cycle after that edge, which is the COMPARE cycle.
- `sweep_done` and updated `min_*` appear one cycle after the last channel's `sample_valid`.
- `new_address` changes one cycle after `sample_valid`.
- Sweep period = NUM_CH·(SETTLE_CYCLES+1)·2·CLK_DIV clocks, steady state.

## Structure
- Package `analog_sensor_scanner_pkg`: state enum {IDLE, SETTLE, SAMPLE, COMPARE}, default parameter constants, 3-bit channel type.
- Sub-module `adc_clk_gen`: divider producing `clk_out` and `rise_tick`, with a hold input driven by IDLE.
- Top level holds the FSM, settle counter and running-min registers.

## Test plan
- Reset with `enable`=0, then release → all outputs at reset values; `clk_out` is static 0 for 100 cycles.
- NUM_CH=4, CLK_DIV=2, SETTLE_CYCLES=1, channels driven {40,12,90,12} → `sample_valid` every 8 clocks; `sweep_done` with `min_address`=1, `min_value`=12 (tie keeps channel 1).
- Same config, all channels 8'hFF → `min_address`=0, `min_value`=8'hFF; second sweep with ch3=0 → `min_address`=3, `min_value`=0.
- `enable` dropped during channel 2 → IDLE next cycle, `new_address`=0, no `sweep_done`, prior `min_*` unchanged; re-enable → sweep restarts at channel 0.
- Async `reset` asserted mid-SAMPLE, off a clock edge → outputs go to reset values immediately, `sample_valid` not pulsed.
- Default params → `clk_out` period 100 clocks; first `sample_valid` 451 clocks after `enable`.
